mac_accel_slave: RTL

Parametrised Avalon-MM slave accelerator: software writes up to eight unsigned operands and a control word, then the block reduces the operands sequentially, one per cycle, using a selectable mode (sum, product, sum of squares, max). It returns a 2×DATA_W result with busy/done/overflow status and an optional interrupt. It is the next-generation replacement for the fixed four-operand adder peripheral on the SoC bus, and plugs into the same slave port.

---
 rtl/mac_accel_pkg.sv | 31 +++
 rtl/mac_accel_alu.sv | 41 ++++
 rtl/mac_accel_slave.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mac_accel_pkg.sv
// Shared types and register map for the operand-reduction accelerator.
package mac_accel_pkg;

  typedef enum logic [1:0] {
    MODE_SUM   = 2'd0,
    MODE_PROD  = 2'd1,
    MODE_SUMSQ = 2'd2,
    MODE_MAX   = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [3:0] ADDR_OP0    = 4'd0;
  localparam logic [3:0] ADDR_CTRL   = 4'd8;
  localparam logic [3:0] ADDR_STATUS = 4'd9;
  localparam logic [3:0] ADDR_RES_LO = 4'd10;
  localparam logic [3:0] ADDR_RES_HI = 4'd11;

  localparam int CTRL_MODE_LSB   = 0;
  localparam int CTRL_MODE_MSB   = 1;
  localparam int CTRL_START_BIT  = 4;
  localparam int CTRL_IRQ_EN_BIT = 5;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_OVF_BIT  = 2;

endpackage

// File: rtl/mac_accel_alu.sv
// One reduction step: folds a single operand into the double-width accumulator.
module mac_accel_alu
  import mac_accel_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  mode_e                 mode,
  input  logic [2*DATA_W-1:0]   acc,
  input  logic [DATA_W-1:0]     op,
  output logic [2*DATA_W-1:0]   next_acc,
  output logic                  ovf
);

  localparam int AW = 2 * DATA_W;
  localparam int PW = 3 * DATA_W;

  logic [AW-1:0] addend;
  logic [AW:0]   add_ext;
  logic [PW-1:0] prod_full;

  always_comb begin
    addend    = (mode == MODE_SUMSQ) ? AW'(op) * AW'(op) : AW'(op);
    add_ext   = {1'b0, acc} + {1'b0, addend};
    prod_full = PW'(acc) * PW'(op);
    next_acc  = add_ext[AW-1:0];
    ovf       = add_ext[AW];
    case (mode)
      // Product overflow is judged on the untruncated 3x-wide result.
      MODE_PROD: begin
        next_acc = prod_full[AW-1:0];
        ovf      = |prod_full[PW-1:AW];
      end
      MODE_MAX: begin
        next_acc = (acc > AW'(op)) ? acc : AW'(op);
        ovf      = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mac_accel_slave.sv
// Avalon-MM slave that reduces N_OPS stored operands, one per cycle, into a
// 2*DATA_W result with sticky done/overflow status and a level interrupt.
module mac_accel_slave
  import mac_accel_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_OPS  = 4
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iChipSelect_n,
  input  logic        iWrite_n,
  input  logic        iRead_n,
  input  logic [3:0]  iAddress,
  input  logic [31:0] iData,
  output logic [31:0] oData,
  output logic        oIrq,
  output state_e      dbg_state
);

  localparam int         AW       = 2 * DATA_W;
  localparam logic [2:0] LAST_IDX = 3'(N_OPS - 1);

  // Bus access: a transfer happens on every edge where select and the strobe
  // are both low; there is no wait-state, reads return data one edge later.
  logic wr_en, rd_en, status_rd, start_acc, busy, last_fold;
  assign wr_en     = !iChipSelect_n && !iWrite_n;
  assign rd_en     = !iChipSelect_n && !iRead_n;
  assign status_rd = rd_en && (iAddress == ADDR_STATUS);

  state_e state, state_nxt;
  logic [DATA_W-1:0] ops [N_OPS];
  mode_e             mode_q;
  logic              irq_en_q, done_q, ovf_q;
  logic [AW-1:0]     acc_q, result_q, alu_acc;
  logic [2:0]        idx_q;
  logic [DATA_W-1:0] op_sel;
  logic              alu_ovf;
  logic [31:0]       rd_data;
  logic [63:0]       res_view;

  assign busy      = (state == ST_RUN);
  assign start_acc = wr_en && (iAddress == ADDR_CTRL) && iData[CTRL_START_BIT] && !busy;
  assign last_fold = busy && (idx_q == LAST_IDX);
  assign dbg_state = state;
  assign oIrq      = done_q & irq_en_q;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_acc) state_nxt = ST_RUN;
      ST_RUN:  if (last_fold) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    op_sel = '0;
    for (int i = 0; i < N_OPS; i++)
      if (idx_q == 3'(i)) op_sel = ops[i];
  end

  mac_accel_alu #(.DATA_W(DATA_W)) u_alu (
    .mode     (mode_q),
    .acc      (acc_q),
    .op       (op_sel),
    .next_acc (alu_acc),
    .ovf      (alu_ovf)
  );

  // Operand and control registers; operands and mode are frozen during a run.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int i = 0; i < N_OPS; i++) ops[i] <= '0;
      mode_q   <= MODE_SUM;
      irq_en_q <= 1'b0;
    end else begin
      if (wr_en && !busy && !iAddress[3]) begin
        for (int i = 0; i < N_OPS; i++)
          if (iAddress[2:0] == 3'(i)) ops[i] <= iData[DATA_W-1:0];
      end
      if (wr_en && (iAddress == ADDR_CTRL)) begin
        irq_en_q <= iData[CTRL_IRQ_EN_BIT];
        if (!busy) mode_q <= mode_e'(iData[CTRL_MODE_MSB:CTRL_MODE_LSB]);
      end
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else if (start_acc) begin
      acc_q <= (mode_e'(iData[CTRL_MODE_MSB:CTRL_MODE_LSB]) == MODE_PROD) ? AW'(1) : '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else if (busy) begin
      acc_q <= alu_acc;
      idx_q <= idx_q + 3'd1;
      if (alu_ovf)   ovf_q    <= 1'b1;
      if (last_fold) result_q <= alu_acc;
    end
  end

  // Completion wins over a coincident STATUS read so the event is never lost.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n)      done_q <= 1'b0;
    else if (start_acc) done_q <= 1'b0;
    else if (last_fold) done_q <= 1'b1;
    else if (status_rd) done_q <= 1'b0;
  end

  always_comb begin
    rd_data            = '0;
    res_view           = '0;
    res_view[AW-1:0]   = result_q;
    case (iAddress)
      ADDR_CTRL: begin
        rd_data[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode_q;
        rd_data[CTRL_IRQ_EN_BIT]             = irq_en_q;
      end
      ADDR_STATUS: begin
        rd_data[STAT_BUSY_BIT] = busy;
        rd_data[STAT_DONE_BIT] = done_q;
        rd_data[STAT_OVF_BIT]  = ovf_q;
      end
      ADDR_RES_LO: rd_data = res_view[31:0];
      ADDR_RES_HI: rd_data = res_view[63:32];
      default: begin
        if (!iAddress[3]) begin
          for (int i = 0; i < N_OPS; i++)
            if (iAddress[2:0] == 3'(i)) rd_data[DATA_W-1:0] = ops[i];
        end
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n)  oData <= '0;
    else if (rd_en) oData <= rd_data;
  end

endmodule
